// File: rtl/quicksort_main_pkg.sv
// Shared types and constants for the quicksort accelerator.
// The ROM holds the fixed 16-byte input reloaded on every start.
package quicksort_main_pkg;

    localparam int ARRAY_LEN = 16;
    localparam int IDX_W     = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PUSH0,
        S_POP,
        S_SCAN,
        S_SWAP1,
        S_SWAP2,
        S_FIN1,
        S_FIN2,
        S_PUSHL,
        S_PUSHR,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] lo;
        logic [IDX_W-1:0] hi;
    } range_t;

    function automatic logic [7:0] rom_at(input logic [IDX_W-1:0] k);
        logic [7:0] v;
        unique case (k)
            4'd0:    v = 8'd57;
            4'd1:    v = 8'd12;
            4'd2:    v = 8'd200;
            4'd3:    v = 8'd3;
            4'd4:    v = 8'd99;
            4'd5:    v = 8'd14;
            4'd6:    v = 8'd255;
            4'd7:    v = 8'd0;
            4'd8:    v = 8'd128;
            4'd9:    v = 8'd77;
            4'd10:   v = 8'd33;
            4'd11:   v = 8'd190;
            4'd12:   v = 8'd7;
            4'd13:   v = 8'd64;
            4'd14:   v = 8'd150;
            default: v = 8'd21;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/quicksort_main_qs_stack.sv
// 16-entry LIFO of (lo,hi) ranges for pending partitions.
// dout always shows the top entry; it is meaningless when empty.
import quicksort_main_pkg::*;

module qs_stack (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  range_t din,
    output range_t dout,
    output logic   empty
);

    range_t           mem_q [ARRAY_LEN];
    logic [IDX_W:0]   sp_q;
    logic [IDX_W:0]   sp_d;
    logic [IDX_W-1:0] top_idx;

    always_comb begin
        sp_d = sp_q;
        if (push) begin
            sp_d = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[sp_q[IDX_W-1:0]] <= din;
        end
    end

    assign top_idx = sp_q[IDX_W-1:0] - 1'b1;
    assign dout    = mem_q[top_idx];
    assign empty   = (sp_q == '0);

endmodule

// File: rtl/quicksort_main.sv
// Quicksort accelerator: loads the ROM, Lomuto-sorts it in place,
// and exposes the array on a 2-channel slave port while idle.
import quicksort_main_pkg::*;

module quicksort_main #(
    parameter int MEM_var_28860_28869 = 32,
    parameter int MEM_var_29118_28866 = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [13:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);

    localparam logic [7:0] WIN_LO = 8'(MEM_var_28860_28869);
    localparam logic [7:0] WIN_HI = 8'(MEM_var_28860_28869 + ARRAY_LEN);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] lo_q, lo_d;
    logic [IDX_W-1:0] hi_q, hi_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [7:0]       pivot_q, pivot_d;
    logic [7:0]       val_q, val_d;
    logic             done_q, done_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [1:0]       rdy_q, rdy_d;
    logic [7:0]       ram_q [ARRAY_LEN];
    logic [7:0]       ram_d [ARRAY_LEN];

    logic             push, pop, empty;
    range_t           push_r, top;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_val;

    logic [1:0]       hit;
    logic [7:0]       a8   [2];
    logic [IDX_W-1:0] off  [2];
    logic [15:0]      m16  [2];
    logic [7:0]       mask [2];
    logic [7:0]       wdat [2];

    logic             unused_ok;

    qs_stack u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_r),
        .dout  (top),
        .empty (empty)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        i_d      = i_q;
        j_d      = j_q;
        pivot_d  = pivot_q;
        val_d    = val_q;
        push     = 1'b0;
        pop      = 1'b0;
        push_r   = '0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_val   = '0;
        done_d   = (state_q == S_POP) && empty;
        unique case (state_q)
            S_IDLE: begin
                if (start_port) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                end
            end
            S_LOAD: begin
                wr_en  = 1'b1;
                wr_idx = k_q;
                wr_val = rom_at(k_q);
                k_d    = k_q + 1'b1;
                if (k_q == IDX_W'(ARRAY_LEN - 1)) begin
                    state_d = S_PUSH0;
                end
            end
            S_PUSH0: begin
                push      = 1'b1;
                push_r.lo = '0;
                push_r.hi = '1;
                state_d   = S_POP;
            end
            S_POP: begin
                if (empty) begin
                    state_d = S_DONE;
                end else begin
                    pop  = 1'b1;
                    lo_d = top.lo;
                    hi_d = top.hi;
                    if (top.lo < top.hi) begin
                        pivot_d = ram_q[top.hi];
                        i_d     = top.lo;
                        j_d     = top.lo;
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (j_q == hi_q) begin
                    state_d = S_FIN1;
                end else if (ram_q[j_q] <= pivot_q) begin
                    val_d   = ram_q[j_q];
                    state_d = S_SWAP1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            // Read-before-write: old RAM[i] is captured while RAM[j] lands there.
            S_SWAP1: begin
                val_d   = ram_q[i_q];
                wr_en   = 1'b1;
                wr_idx  = i_q;
                wr_val  = val_q;
                state_d = S_SWAP2;
            end
            S_SWAP2: begin
                wr_en   = 1'b1;
                wr_idx  = j_q;
                wr_val  = val_q;
                i_d     = i_q + 1'b1;
                j_d     = j_q + 1'b1;
                state_d = S_SCAN;
            end
            S_FIN1: begin
                val_d   = ram_q[i_q];
                wr_en   = 1'b1;
                wr_idx  = i_q;
                wr_val  = pivot_q;
                state_d = S_FIN2;
            end
            S_FIN2: begin
                wr_en   = 1'b1;
                wr_idx  = hi_q;
                wr_val  = val_q;
                state_d = S_PUSHL;
            end
            S_PUSHL: begin
                if (i_q > lo_q) begin
                    push      = 1'b1;
                    push_r.lo = lo_q;
                    push_r.hi = i_q - 1'b1;
                end
                state_d = S_PUSHR;
            end
            S_PUSHR: begin
                if (i_q < hi_q) begin
                    push      = 1'b1;
                    push_r.lo = i_q + 1'b1;
                    push_r.hi = hi_q;
                end
                state_d = S_POP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            a8[c]   = {1'b0, S_addr_ram[7*c +: 7]};
            hit[c]  = (a8[c] >= WIN_LO) && (a8[c] < WIN_HI);
            off[c]  = a8[c][IDX_W-1:0] - WIN_LO[IDX_W-1:0];
            m16[c]  = (16'd1 << S_data_ram_size[4*c +: 4]) - 16'd1;
            mask[c] = m16[c][7:0];
            wdat[c] = S_Wdata_ram[8*c +: 8];
        end
    end

    // Channel 1 is applied last, so it wins a same-byte write.
    always_comb begin
        ram_d   = ram_q;
        rdy_d   = '0;
        rdata_d = '0;
        if (wr_en) begin
            ram_d[wr_idx] = wr_val;
        end
        for (int c = 0; c < 2; c++) begin
            if (state_q == S_IDLE && hit[c]
                && (S_oe_ram[c] || S_we_ram[c])) begin
                rdy_d[c] = 1'b1;
                if (S_we_ram[c]) begin
                    ram_d[off[c]] = (wdat[c] & mask[c])
                                  | (ram_q[off[c]] & ~mask[c]);
                end else begin
                    rdata_d[8*c +: 8] = ram_q[off[c]];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pivot_q <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            rdy_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pivot_q <= pivot_d;
            val_q   <= val_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clock) begin
        ram_q <= ram_d;
    end

    assign done_port          = done_q;
    assign Sout_Rdata_ram     = rdata_q;
    assign Sout_DataRdy       = rdy_q;
    assign Mout_oe_ram        = '0;
    assign Mout_we_ram        = '0;
    assign Mout_addr_ram      = '0;
    assign Mout_Wdata_ram     = '0;
    assign Mout_data_ram_size = '0;

    // Master bus and stack label exist only for interface compatibility.
    assign unused_ok = ^{M_Rdata_ram, M_DataRdy, 32'(MEM_var_29118_28866)};

endmodule

// File: tb/tb_quicksort_main.sv
// Randomized bench for quicksort_main against a sorted-array
// reference and a byte-array model of the slave port.
module tb_quicksort_main;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_port;
    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram;
    logic [1:0]  Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    int n_cmp = 0;
    int n_err = 0;
    int mout_bad = 0;

    logic [7:0] rom [16] = '{8'd57, 8'd12, 8'd200, 8'd3, 8'd99, 8'd14,
                             8'd255, 8'd0, 8'd128, 8'd77, 8'd33, 8'd190,
                             8'd7, 8'd64, 8'd150, 8'd21};
    logic [7:0] mdl [16];

    quicksort_main dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .done_port          (done_port),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if ({Mout_oe_ram, Mout_we_ram, Mout_addr_ram,
             Mout_Wdata_ram, Mout_data_ram_size} != '0)
            mout_bad++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_sorted();
        int v [16];
        int t;
        for (int k = 0; k < 16; k++) v[k] = int'(rom[k]);
        for (int a = 1; a < 16; a++) begin
            for (int b = a; b > 0 && v[b-1] > v[b]; b--) begin
                t = v[b]; v[b] = v[b-1]; v[b-1] = t;
            end
        end
        for (int k = 0; k < 16; k++) mdl[k] = 8'(v[k]);
    endtask

    function automatic logic [7:0] size_mask(input int sz);
        if (sz >= 8) return 8'hFF;
        return 8'((1 << sz) - 1);
    endfunction

    task automatic run_sort(input bit poke, output int lat);
        int n = 1;
        start_port = 1'b1;
        tick();
        start_port = 1'b0;
        while (!done_port && n < 2000) begin
            start_port = poke && (n == 50);
            tick();
            n++;
        end
        start_port = 1'b0;
        check("done_seen", done_port, 1);
        lat = n;
        tick();
        check("done_one_cycle", done_port, 0);
    endtask

    task automatic slave_rd(input int ch, input logic [6:0] addr,
                            input int budget, output logic [7:0] d,
                            output logic r);
        int n = 0;
        S_oe_ram[ch] = 1'b1;
        S_addr_ram[7*ch +: 7] = addr;
        tick();
        while (!Sout_DataRdy[ch] && n < budget) begin
            tick();
            n++;
        end
        r = Sout_DataRdy[ch];
        d = Sout_Rdata_ram[8*ch +: 8];
        S_oe_ram[ch] = 1'b0;
    endtask

    task automatic read_all(input string tag);
        logic [7:0] d;
        logic r;
        for (int k = 0; k < 16; k++) begin
            slave_rd(k % 2, 7'(32 + k), 5, d, r);
            check({tag, "_rdy"}, r, 1);
            check({tag, "_data"}, d, mdl[k]);
        end
    endtask

    initial begin
        int lat1, lat2, lat3, n;
        logic [7:0] d, wd;
        logic r, oe, we, saw_done, inwin;
        logic [6:0] addr;
        int ch, sz;

        reset = 1'b1;
        start_port = 1'b0;
        S_oe_ram = '0;
        S_we_ram = '0;
        S_addr_ram = '0;
        S_Wdata_ram = '0;
        S_data_ram_size = '0;
        M_Rdata_ram = 16'hDEAD;
        M_DataRdy = 2'b11;
        tick();
        tick();
        check("rst_done", done_port, 0);
        check("rst_rdy", Sout_DataRdy, 0);
        check("rst_rdata", Sout_Rdata_ram, 0);
        reset = 1'b0;
        tick();

        run_sort(1'b0, lat1);
        check("lat_lt_700", lat1 < 700, 1);
        model_sorted();
        check("model_min", mdl[0], 8'd0);
        read_all("sort1");

        S_we_ram[0] = 1'b1;
        S_addr_ram[6:0] = 7'd33;
        S_Wdata_ram[7:0] = 8'hAA;
        S_data_ram_size[3:0] = 4'd8;
        tick();
        check("wr_ch0_rdy", Sout_DataRdy[0], 1);
        S_we_ram[0] = 1'b0;
        S_oe_ram[1] = 1'b1;
        S_addr_ram[13:7] = 7'd33;
        tick();
        check("rd_ch1_rdy", Sout_DataRdy[1], 1);
        check("rd_ch1_data", Sout_Rdata_ram[15:8], 8'hAA);
        S_oe_ram[1] = 1'b0;
        mdl[1] = 8'hAA;

        slave_rd(0, 7'd31, 0, d, r);
        check("oow31_rdy", r, 0);
        check("oow31_data", Sout_Rdata_ram, 0);
        slave_rd(1, 7'd48, 0, d, r);
        check("oow48_rdy", r, 0);
        check("oow48_data", Sout_Rdata_ram, 0);

        S_we_ram = 2'b11;
        S_addr_ram = {7'd40, 7'd40};
        S_Wdata_ram = 16'h2211;
        S_data_ram_size = 8'h88;
        tick();
        check("dual_wr_rdy", Sout_DataRdy, 2'b11);
        S_we_ram = 2'b00;
        mdl[8] = 8'h22;
        slave_rd(0, 7'd40, 5, d, r);
        check("dual_wr_data", d, 8'h22);

        for (int t = 0; t < 60; t++) begin
            ch = int'($urandom_range(0, 1));
            addr = 7'($urandom_range(28, 51));
            oe = 1'($urandom);
            we = 1'($urandom);
            if (!oe && !we) oe = 1'b1;
            wd = 8'($urandom);
            sz = int'($urandom_range(0, 15));
            inwin = (addr >= 7'd32) && (addr < 7'd48);
            S_oe_ram[ch] = oe;
            S_we_ram[ch] = we;
            S_addr_ram[7*ch +: 7] = addr;
            S_Wdata_ram[8*ch +: 8] = wd;
            S_data_ram_size[4*ch +: 4] = 4'(sz);
            tick();
            check("rnd_rdy", Sout_DataRdy[ch], inwin);
            if (inwin && we) begin
                mdl[addr - 7'd32] = (wd & size_mask(sz))
                                  | (mdl[addr - 7'd32] & ~size_mask(sz));
            end else if (inwin) begin
                check("rnd_rdata", Sout_Rdata_ram[8*ch +: 8],
                      mdl[addr - 7'd32]);
            end else begin
                check("rnd_oow_data", Sout_Rdata_ram, 0);
            end
            S_oe_ram = '0;
            S_we_ram = '0;
        end
        read_all("rnd_final");

        run_sort(1'b1, lat2);
        check("lat_equal_rerun", lat2, lat1);
        model_sorted();
        read_all("sort2");

        start_port = 1'b1;
        tick();
        start_port = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        S_oe_ram[1] = 1'b1;
        S_addr_ram[13:7] = 7'd37;
        saw_done = 1'b0;
        n = 0;
        tick();
        while (!Sout_DataRdy[1] && n < 2000) begin
            if (done_port) saw_done = 1'b1;
            tick();
            n++;
        end
        check("busy_rd_after_done", saw_done, 1);
        check("busy_rd_rdy", Sout_DataRdy[1], 1);
        check("busy_rd_data", Sout_Rdata_ram[15:8], mdl[5]);
        S_oe_ram[1] = 1'b0;
        tick();

        start_port = 1'b1;
        tick();
        start_port = 1'b0;
        n = int'($urandom_range(20, 150));
        for (int k = 0; k < n; k++) tick();
        reset = 1'b1;
        tick();
        check("abort_done", done_port, 0);
        tick();
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 700; k++) begin
            tick();
            if (done_port) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        run_sort(1'b0, lat3);
        check("lat_equal_after_rst", lat3, lat1);
        read_all("sort3");

        check("mout_idle", mout_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
